// File: rtl/encrypt_pipe_shift.sv
// rtl/encrypt_pipe_shift.sv - two-stage Caesar-shift encrypt stage producing extended one-hot letters
module encrypt_pipe_shift #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               shift_en,
   input  logic [2:0]         shift_amt,
   input  logic               mode,
   input  logic [7:0]         data_in,
   input  logic               clr_count,
   output logic               en_out,
   output logic [31:0]        extended_shift_out,
   output logic               is_alpha_upper_case,
   output logic               is_alpha_low_case,
   output logic [COUNT_W-1:0] enc_count
);

   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   // stage 1 registers
   logic        s1_valid_q, s1_valid_d;
   logic        s1_upper_q, s1_upper_d;
   logic        s1_lower_q, s1_lower_d;
   logic [4:0]  s1_k_q, s1_k_d;
   logic [7:0]  s1_byte_q, s1_byte_d;
   logic        s1_shift_en_q, s1_shift_en_d;
   logic [2:0]  s1_amt_q, s1_amt_d;
   logic        s1_mode_q, s1_mode_d;

   // stage 2 (output) registers
   logic               en_out_q, en_out_d;
   logic [31:0]        ext_q, ext_d;
   logic               upper_q, upper_d;
   logic               lower_q, lower_d;
   logic [COUNT_W-1:0] enc_count_q, enc_count_d;

   logic       in_upper;
   logic       in_lower;
   logic       do_shift;
   logic [5:0] rot_sum;
   logic [5:0] rot_k;

   // Stage 1: classify the byte and capture it with the controls that travel alongside it
   always_comb begin
      in_upper      = (data_in >= 8'h41) && (data_in <= 8'h5A);
      in_lower      = (data_in >= 8'h61) && (data_in <= 8'h7A);
      s1_valid_d    = en;
      s1_upper_d    = en & in_upper;
      s1_lower_d    = en & in_lower;
      s1_k_d        = s1_k_q;
      s1_byte_d     = s1_byte_q;
      s1_shift_en_d = s1_shift_en_q;
      s1_amt_d      = s1_amt_q;
      s1_mode_d     = s1_mode_q;
      if (en) begin
         // 'A' and 'a' both have 5'b00001 in their low bits, so one subtract serves both cases
         s1_k_d        = (in_upper || in_lower) ? (data_in[4:0] - 5'd1) : 5'd0;
         s1_byte_d     = data_in;
         s1_shift_en_d = shift_en;
         s1_amt_d      = shift_amt;
         s1_mode_d     = mode;
      end
   end

   // Stage 2: rotate letters into the one-hot field, pass everything else through, count shifted letters
   always_comb begin
      do_shift = s1_valid_q && (s1_upper_q || s1_lower_q) && !s1_mode_q && s1_shift_en_q;
      // k + amt is at most 32, so a single conditional subtract gives the mod-26 result
      rot_sum  = {1'b0, s1_k_q} + {3'b000, s1_amt_q};
      rot_k    = (rot_sum >= 6'd26) ? (rot_sum - 6'd26) : rot_sum;
      en_out_d = s1_valid_q;
      upper_d  = s1_valid_q & s1_upper_q;
      lower_d  = s1_valid_q & s1_lower_q;
      ext_d    = 32'h0;
      if (do_shift) begin
         ext_d = 32'h0000_0040 << rot_k;
      end else if (s1_valid_q) begin
         ext_d = {24'h0, s1_byte_q};
      end
      enc_count_d = enc_count_q;
      if (clr_count) begin
         enc_count_d = '0;
      end else if (do_shift && !(&enc_count_q)) begin
         enc_count_d = enc_count_q + COUNT_ONE;
      end
   end

   // Pipeline and counter state; reset drops anything in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q    <= 1'b0;
         s1_upper_q    <= 1'b0;
         s1_lower_q    <= 1'b0;
         s1_k_q        <= 5'd0;
         s1_byte_q     <= 8'h0;
         s1_shift_en_q <= 1'b0;
         s1_amt_q      <= 3'd0;
         s1_mode_q     <= 1'b0;
         en_out_q      <= 1'b0;
         ext_q         <= 32'h0;
         upper_q       <= 1'b0;
         lower_q       <= 1'b0;
         enc_count_q   <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_upper_q    <= s1_upper_d;
         s1_lower_q    <= s1_lower_d;
         s1_k_q        <= s1_k_d;
         s1_byte_q     <= s1_byte_d;
         s1_shift_en_q <= s1_shift_en_d;
         s1_amt_q      <= s1_amt_d;
         s1_mode_q     <= s1_mode_d;
         en_out_q      <= en_out_d;
         ext_q         <= ext_d;
         upper_q       <= upper_d;
         lower_q       <= lower_d;
         enc_count_q   <= enc_count_d;
      end
   end

   assign en_out              = en_out_q;
   assign extended_shift_out  = ext_q;
   assign is_alpha_upper_case = upper_q;
   assign is_alpha_low_case   = lower_q;
   assign enc_count           = enc_count_q;

endmodule
